// File: rtl/wb_regfile.sv
// MIPS-style register file with writeback-select logic for the MEM/WB stage.
// 32 x 32-bit registers, two combinational read ports, one write port, and a
// registered count of committed writes. Register 0 is hardwired to zero.
// Optional feature: define WB_REGFILE_BYPASS_EN to let a same-cycle write be
// seen on the read ports (write-before-read). Without it, reads return stored
// data and the ID stage is expected to forward externally.
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_PC,
    input  logic        in_Ctrl_Jal,
    input  logic        in_Ctrl_RegWrite,
    input  logic        in_Ctrl_MemToReg,
    input  logic [31:0] in_RAM_Read_Data,
    input  logic [31:0] in_ALU_Result,
    input  logic [4:0]  in_Write_Register,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [31:0] commit_count
);

    localparam logic [4:0] RegRa = 5'd31;

    logic [31:0] regs_q [32];
    logic [31:0] commit_count_q;
    logic [31:0] rs_stored;
    logic [31:0] rt_stored;

    // Writeback destination, data and enable; jal overrides the normal path.
    always_comb begin
        wb_reg = in_Ctrl_Jal ? RegRa : in_Write_Register;
        if (in_Ctrl_Jal) begin
            wb_data = in_PC;
        end else if (in_Ctrl_MemToReg) begin
            wb_data = in_RAM_Read_Data;
        end else begin
            wb_data = in_ALU_Result;
        end
        // A write aimed at register 0 is not a write at all.
        wb_we = (in_Ctrl_RegWrite | in_Ctrl_Jal) & (wb_reg != 5'd0);
    end

    // Storage reads; register 0 is forced to zero regardless of contents.
    always_comb begin
        rs_stored = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
        rt_stored = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];
    end

`ifdef WB_REGFILE_BYPASS_EN
    // Same-cycle bypass: a matching pending write wins over stored data.
    always_comb begin
        rs_data = (wb_we && (rs_addr == wb_reg)) ? wb_data : rs_stored;
        rt_data = (wb_we && (rt_addr == wb_reg)) ? wb_data : rt_stored;
    end
`else
    // No bypass: ports always show pre-write storage.
    always_comb begin
        rs_data = rs_stored;
        rt_data = rt_stored;
    end
`endif

    // Register array update; reset clears every entry and masks the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wb_we) begin
            regs_q[wb_reg] <= wb_data;
        end
    end

    // Committed-write counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_count_q <= 32'd0;
        end else if (wb_we) begin
            commit_count_q <= commit_count_q + 32'd1;
        end
    end

    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic
// against a register-array reference model.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] in_PC;
    logic        in_Ctrl_Jal;
    logic        in_Ctrl_RegWrite;
    logic        in_Ctrl_MemToReg;
    logic [31:0] in_RAM_Read_Data;
    logic [31:0] in_ALU_Result;
    logic [4:0]  in_Write_Register;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] commit_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_count;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    wb_regfile dut (
        .clk               (clk),
        .reset             (reset),
        .in_PC             (in_PC),
        .in_Ctrl_Jal       (in_Ctrl_Jal),
        .in_Ctrl_RegWrite  (in_Ctrl_RegWrite),
        .in_Ctrl_MemToReg  (in_Ctrl_MemToReg),
        .in_RAM_Read_Data  (in_RAM_Read_Data),
        .in_ALU_Result     (in_ALU_Result),
        .in_Write_Register (in_Write_Register),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .wb_we             (wb_we),
        .wb_reg            (wb_reg),
        .wb_data           (wb_data),
        .commit_count      (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the writeback stage should do with the current inputs.
    function automatic logic [4:0] exp_reg();
        return in_Ctrl_Jal ? 5'd31 : in_Write_Register;
    endfunction

    function automatic logic [31:0] exp_data();
        if (in_Ctrl_Jal) return in_PC;
        if (in_Ctrl_MemToReg) return in_RAM_Read_Data;
        return in_ALU_Result;
    endfunction

    function automatic logic exp_we();
        return (in_Ctrl_RegWrite || in_Ctrl_Jal) && (exp_reg() != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (Bypass && exp_we() && a == exp_reg()) return exp_data();
        return model_regs[a];
    endfunction

    task automatic set_in(input logic jal, input logic rw, input logic m2r,
                          input logic [31:0] pc, input logic [31:0] ram,
                          input logic [31:0] alu, input logic [4:0] wr,
                          input logic [4:0] ra, input logic [4:0] rb);
        in_Ctrl_Jal = jal;
        in_Ctrl_RegWrite = rw;
        in_Ctrl_MemToReg = m2r;
        in_PC = pc;
        in_RAM_Read_Data = ram;
        in_ALU_Result = alu;
        in_Write_Register = wr;
        rs_addr = ra;
        rt_addr = rb;
    endtask

    // Check combinational outputs, clock once, update model, check counter.
    task automatic step(input bit full);
        #1;
        if (full) begin
            chk("wb_we", {31'd0, wb_we}, {31'd0, exp_we()});
            chk("wb_reg", {27'd0, wb_reg}, {27'd0, exp_reg()});
            chk("wb_data", wb_data, exp_data());
            chk("rs_data", rs_data, exp_read(rs_addr));
            chk("rt_data", rt_data, exp_read(rt_addr));
        end
        @(posedge clk);
        if (exp_we()) begin
            model_regs[exp_reg()] = exp_data();
            model_count = model_count + 32'd1;
        end
        #1;
        chk("commit_count", commit_count, model_count);
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, a, a);
        #1;
        chk(tag, rs_data, exp);
        chk(tag, rt_data, exp);
    endtask

    initial begin
        logic [31:0] old9;
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
        @(negedge clk);
        #1;
        chk("reset_count", commit_count, 32'd0);
        read_chk("reset_r7", 5'd7, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // b) ALU writeback to r8.
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h1234_5678, 5'd8, 5'd1, 5'd2);
        step(1'b1);
        read_chk("b_r8", 5'd8, 32'h1234_5678);
        chk("b_count", commit_count, 32'd1);

        // c) load to r0 is discarded.
        set_in(1'b0, 1'b1, 1'b1, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("c_we", {31'd0, wb_we}, 32'd0);
        step(1'b1);
        read_chk("c_r0", 5'd0, 32'd0);
        chk("c_count", commit_count, 32'd1);

        // d) jal writes r31 with PC; r5 untouched.
        set_in(1'b1, 1'b0, 1'b0, 32'h0040_0024, 32'd0, 32'd0, 5'd5, 5'd31, 5'd5);
        step(1'b1);
        read_chk("d_r31", 5'd31, 32'h0040_0024);
        read_chk("d_r5", 5'd5, 32'd0);

        // e) same-cycle read of the register being written.
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h1111_2222, 5'd9, 5'd0, 5'd0);
        step(1'b1);
        old9 = 32'h1111_2222;
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
        #1;
        chk("e_rs", rs_data, Bypass ? 32'hA5A5_A5A5 : old9);
        chk("e_rt", rt_data, Bypass ? 32'hA5A5_A5A5 : old9);
        step(1'b1);
        read_chk("e_after", 5'd9, 32'hA5A5_A5A5);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            set_in(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, wr,
                   ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            step(1'b1);
        end

        // a) mid-cycle reset with a write pending; all registers clear.
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hCAFE_F00D, 5'd12, 5'd0, 5'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
        #1;
        chk("a_count", commit_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            read_chk("a_reg", 5'(i), 32'd0);
        end
        chk("a_count2", commit_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0077, 5'd3, 5'd3, 5'd0);
        step(1'b1);
        read_chk("a_resume", 5'd3, 32'h0000_0077);

        // f) counter wrap.
        force dut.commit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_count_q;
        #1;
        model_count = 32'hFFFF_FFFF;
        chk("f_preload", commit_count, 32'hFFFF_FFFF);
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h55, 5'd0, 5'd0, 5'd0);
        step(1'b1);
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h66, 5'd4, 5'd4, 5'd0);
        step(1'b1);
        chk("f_wrap", commit_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
